// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Sequencing controller for the 5-stage pipeline. Produces the
//               enables and clears for PC, IF/ID, ID/EX and EX/MEM, handles
//               memory freeze, redirect flush, load-use stall and HLT drain,
//               and keeps saturating stall and flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_hlt,
    input  logic             ex_MemRead,
    input  logic [3:0]       ex_Rd,
    input  logic             mem_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write_en,
    output logic             if_id_write_en,
    output logic             if_id_clear,
    output logic             id_ex_write_en,
    output logic             id_ex_clear,
    output logic             ex_mem_write_en,
    output logic             ex_mem_clear,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int c_DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t               r_state_q;
    state_t               w_state_d;
    logic [c_DRAIN_W-1:0] r_drain_q;
    logic [c_DRAIN_W-1:0] w_drain_d;
    logic [CNT_W-1:0]     r_stall_q;
    logic [CNT_W-1:0]     w_stall_d;
    logic [CNT_W-1:0]     r_flush_q;
    logic [CNT_W-1:0]     w_flush_d;

    logic w_freeze;
    logic w_load_use;

    assign w_freeze = mem_req & ~mem_ready;

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign w_load_use = ex_MemRead && (ex_Rd != 4'd0) &&
                        ((id_use_rs && (id_rs == ex_Rd)) ||
                         (id_use_rt && (id_rt == ex_Rd)));

    assign stall_count = r_stall_q;
    assign flush_count = r_flush_q;

    always_comb begin
        w_state_d       = r_state_q;
        w_drain_d       = r_drain_q;
        w_stall_d       = r_stall_q;
        w_flush_d       = r_flush_q;
        pc_write_en     = 1'b0;
        if_id_write_en  = 1'b0;
        if_id_clear     = 1'b0;
        id_ex_write_en  = 1'b0;
        id_ex_clear     = 1'b0;
        ex_mem_write_en = 1'b0;
        ex_mem_clear    = 1'b0;
        halted          = 1'b0;

        if (rst) begin
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            ex_mem_clear = 1'b1;
        end else begin
            case (r_state_q)
                S_RUN: begin
                    if (w_freeze) begin
                        // everything holds
                    end else if (mem_redirect) begin
                        pc_write_en  = 1'b1;
                        if_id_clear  = 1'b1;
                        id_ex_clear  = 1'b1;
                        ex_mem_clear = 1'b1;
                        if (r_flush_q != {CNT_W{1'b1}}) begin
                            w_flush_d = r_flush_q + CNT_W'(1);
                        end
                    end else if (w_load_use) begin
                        id_ex_clear     = 1'b1;
                        ex_mem_write_en = 1'b1;
                        if (r_stall_q != {CNT_W{1'b1}}) begin
                            w_stall_d = r_stall_q + CNT_W'(1);
                        end
                    end else if (id_hlt) begin
                        // HLT moves into ID/EX while fetch stops behind it.
                        if_id_clear     = 1'b1;
                        id_ex_write_en  = 1'b1;
                        ex_mem_write_en = 1'b1;
                        w_state_d       = S_DRAIN;
                        w_drain_d       = c_DRAIN_W'(DRAIN_CYCLES);
                    end else begin
                        pc_write_en     = 1'b1;
                        if_id_write_en  = 1'b1;
                        id_ex_write_en  = 1'b1;
                        ex_mem_write_en = 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (w_freeze) begin
                        // drain counter holds while memory stalls
                    end else if (mem_redirect) begin
                        // An older branch squashed the HLT: resume normal flow.
                        pc_write_en  = 1'b1;
                        if_id_clear  = 1'b1;
                        id_ex_clear  = 1'b1;
                        ex_mem_clear = 1'b1;
                        if (r_flush_q != {CNT_W{1'b1}}) begin
                            w_flush_d = r_flush_q + CNT_W'(1);
                        end
                        w_state_d = S_RUN;
                        w_drain_d = '0;
                    end else begin
                        if_id_clear     = 1'b1;
                        id_ex_write_en  = 1'b1;
                        ex_mem_write_en = 1'b1;
                        w_drain_d       = r_drain_q - c_DRAIN_W'(1);
                        if (r_drain_q == c_DRAIN_W'(1)) begin
                            w_state_d = S_HALTED;
                        end
                    end
                end

                S_HALTED: begin
                    halted = 1'b1;
                end

                default: begin
                    w_state_d = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_RUN;
            r_drain_q <= '0;
            r_stall_q <= '0;
            r_flush_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_drain_q <= w_drain_d;
            r_stall_q <= w_stall_d;
            r_flush_q <= w_flush_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl: directed
//               scenarios with literal expectations plus randomized traffic
//               compared every cycle against an event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int c_DRAIN   = 4;
    localparam int c_CNT_W   = 16;
    localparam int c_CNT_MAX = (1 << c_CNT_W) - 1;

    // Output vector order: pc_we, if_id_we, if_id_clr, id_ex_we, id_ex_clr,
    // ex_mem_we, ex_mem_clr, halted
    localparam logic [7:0] c_V_RESET  = 8'b0010_1010;
    localparam logic [7:0] c_V_FREEZE = 8'b0000_0000;
    localparam logic [7:0] c_V_REDIR  = 8'b1010_1010;
    localparam logic [7:0] c_V_LU     = 8'b0000_1100;
    localparam logic [7:0] c_V_DRAIN  = 8'b0011_0100;
    localparam logic [7:0] c_V_RUN    = 8'b1101_0100;
    localparam logic [7:0] c_V_HALT   = 8'b0000_0001;

    localparam int c_EV_RESET  = 0;
    localparam int c_EV_HALTED = 1;
    localparam int c_EV_FREEZE = 2;
    localparam int c_EV_REDIR  = 3;
    localparam int c_EV_LU     = 4;
    localparam int c_EV_HLT    = 5;
    localparam int c_EV_DRAIN  = 6;
    localparam int c_EV_RUN    = 7;

    localparam int c_M_RUN    = 0;
    localparam int c_M_DRAIN  = 1;
    localparam int c_M_HALTED = 2;

    logic               clk;
    logic               rst;
    logic [3:0]         id_rs;
    logic [3:0]         id_rt;
    logic               id_use_rs;
    logic               id_use_rt;
    logic               id_hlt;
    logic               ex_MemRead;
    logic [3:0]         ex_Rd;
    logic               mem_redirect;
    logic               mem_req;
    logic               mem_ready;
    logic               pc_write_en;
    logic               if_id_write_en;
    logic               if_id_clear;
    logic               id_ex_write_en;
    logic               id_ex_clear;
    logic               ex_mem_write_en;
    logic               ex_mem_clear;
    logic               halted;
    logic [c_CNT_W-1:0] stall_count;
    logic [c_CNT_W-1:0] flush_count;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (c_DRAIN),
        .CNT_W        (c_CNT_W)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_hlt          (id_hlt),
        .ex_MemRead      (ex_MemRead),
        .ex_Rd           (ex_Rd),
        .mem_redirect    (mem_redirect),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write_en     (pc_write_en),
        .if_id_write_en  (if_id_write_en),
        .if_id_clear     (if_id_clear),
        .id_ex_write_en  (id_ex_write_en),
        .id_ex_clear     (id_ex_clear),
        .ex_mem_write_en (ex_mem_write_en),
        .ex_mem_clear    (ex_mem_clear),
        .halted          (halted),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pipeline mode, remaining drain cycles, event counts.
    int m_mode  = c_M_RUN;
    int m_left  = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_valid = 1'b0;

    // Literal expectations posted by the directed stimulus for this cycle.
    bit         lit_vec_on = 1'b0;
    bit         lit_cnt_on = 1'b0;
    logic [7:0] lit_vec    = '0;
    string      lit_name   = "";
    int         lit_stall  = 0;
    int         lit_flush  = 0;

    function automatic int sat_inc(input int x);
        return (x >= c_CNT_MAX) ? c_CNT_MAX : x + 1;
    endfunction

    function automatic bit load_use_hit();
        if (!ex_MemRead || ex_Rd == 4'd0) return 1'b0;
        return (id_use_rs && id_rs == ex_Rd) || (id_use_rt && id_rt == ex_Rd);
    endfunction

    function automatic int classify();
        if (rst)                    return c_EV_RESET;
        if (m_mode == c_M_HALTED)   return c_EV_HALTED;
        if (mem_req && !mem_ready)  return c_EV_FREEZE;
        if (mem_redirect)           return c_EV_REDIR;
        if (m_mode == c_M_DRAIN)    return c_EV_DRAIN;
        if (load_use_hit())         return c_EV_LU;
        if (id_hlt)                 return c_EV_HLT;
        return c_EV_RUN;
    endfunction

    function automatic logic [7:0] ev_vec(input int ev);
        case (ev)
            c_EV_RESET:  return c_V_RESET;
            c_EV_HALTED: return c_V_HALT;
            c_EV_FREEZE: return c_V_FREEZE;
            c_EV_REDIR:  return c_V_REDIR;
            c_EV_LU:     return c_V_LU;
            c_EV_HLT:    return c_V_DRAIN;
            c_EV_DRAIN:  return c_V_DRAIN;
            default:     return c_V_RUN;
        endcase
    endfunction

    always begin : p_compare
        int         ev;
        logic [7:0] act;
        logic [7:0] exp_v;
        int         n_mode;
        int         n_left;
        int         n_stall;
        int         n_flush;
        bit         n_valid;

        @(negedge clk);
        ev    = classify();
        act   = {pc_write_en, if_id_write_en, if_id_clear, id_ex_write_en,
                 id_ex_clear, ex_mem_write_en, ex_mem_clear, halted};
        exp_v = ev_vec(ev);

        n_checks++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL ctrl_vec t=%0t ev=%0d: got %b want %b", $time, ev, act, exp_v);
        end
        if (m_valid) begin
            n_checks++;
            if (stall_count !== c_CNT_W'(m_stall) || flush_count !== c_CNT_W'(m_flush)) begin
                n_err++;
                $display("FAIL counters t=%0t: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         $time, stall_count, flush_count, m_stall, m_flush);
            end
        end
        if (lit_vec_on) begin
            n_checks++;
            if (act !== lit_vec) begin
                n_err++;
                $display("FAIL %s t=%0t: got %b want %b", lit_name, $time, act, lit_vec);
            end
        end
        if (lit_cnt_on) begin
            n_checks++;
            if (stall_count !== c_CNT_W'(lit_stall) || flush_count !== c_CNT_W'(lit_flush)) begin
                n_err++;
                $display("FAIL %s_cnt t=%0t: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                         lit_name, $time, stall_count, flush_count, lit_stall, lit_flush);
            end
        end

        n_mode  = m_mode;
        n_left  = m_left;
        n_stall = m_stall;
        n_flush = m_flush;
        n_valid = m_valid;
        case (ev)
            c_EV_RESET: begin
                n_mode  = c_M_RUN;
                n_left  = 0;
                n_stall = 0;
                n_flush = 0;
                n_valid = 1'b1;
            end
            c_EV_REDIR: begin
                n_flush = sat_inc(m_flush);
                n_mode  = c_M_RUN;
                n_left  = 0;
            end
            c_EV_LU: n_stall = sat_inc(m_stall);
            c_EV_HLT: begin
                n_mode = c_M_DRAIN;
                n_left = c_DRAIN;
            end
            c_EV_DRAIN: begin
                n_left = m_left - 1;
                if (n_left == 0) n_mode = c_M_HALTED;
            end
            default: ;
        endcase

        @(posedge clk);
        m_mode  = n_mode;
        m_left  = n_left;
        m_stall = n_stall;
        m_flush = n_flush;
        m_valid = n_valid;
    end

    task automatic idle();
        id_rs        = 4'd0;
        id_rt        = 4'd0;
        id_use_rs    = 1'b0;
        id_use_rt    = 1'b0;
        id_hlt       = 1'b0;
        ex_MemRead   = 1'b0;
        ex_Rd        = 4'd0;
        mem_redirect = 1'b0;
        mem_req      = 1'b0;
        mem_ready    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        lit_vec_on = 1'b0;
        lit_cnt_on = 1'b0;
    endtask

    task automatic want(input logic [7:0] v, input string nm);
        lit_vec    = v;
        lit_name   = nm;
        lit_vec_on = 1'b1;
    endtask

    task automatic want_cnt(input int s, input int f);
        lit_stall  = s;
        lit_flush  = f;
        lit_cnt_on = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        want(c_V_RESET, "reset");
        tick();
        rst = 1'b0;
    endtask

    task automatic set_lu_rs5();
        ex_MemRead = 1'b1;
        ex_Rd      = 4'd5;
        id_rs      = 4'd5;
        id_use_rs  = 1'b1;
    endtask

    initial begin : p_stim
        rst = 1'b1;
        idle();

        want(c_V_RESET, "rst_c0");                      tick();
        want(c_V_RESET, "rst_c1"); want_cnt(0, 0);      tick();
        rst = 1'b0;
        want(c_V_RUN, "run_after_rst"); want_cnt(0, 0); tick();

        set_lu_rs5();
        want(c_V_LU, "lu_hit_rs");                      tick();
        idle();
        want(c_V_RUN, "lu_done"); want_cnt(1, 0);       tick();
        ex_MemRead = 1'b1; ex_Rd = 4'd0; id_rs = 4'd0; id_use_rs = 1'b1;
        want(c_V_RUN, "lu_rd0");                        tick();
        ex_Rd = 4'd5; id_rs = 4'd5; id_use_rs = 1'b0;
        want(c_V_RUN, "lu_nouse");                      tick();
        idle(); ex_MemRead = 1'b1; ex_Rd = 4'd7; id_rt = 4'd7; id_use_rt = 1'b1;
        want(c_V_LU, "lu_hit_rt"); want_cnt(1, 0);      tick();
        idle();
        want(c_V_RUN, "lu_rt_done"); want_cnt(2, 0);    tick();

        do_reset();
        set_lu_rs5(); mem_redirect = 1'b1;
        want(c_V_REDIR, "redir_over_lu");               tick();
        idle();
        want(c_V_RUN, "after_redir"); want_cnt(0, 1);   tick();

        mem_redirect = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            want(c_V_FREEZE, "freeze"); want_cnt(0, 1); tick();
        end
        mem_ready = 1'b1;
        want(c_V_REDIR, "freeze_release"); want_cnt(0, 1); tick();
        idle();
        want(c_V_RUN, "after_freeze"); want_cnt(0, 2);  tick();

        do_reset();
        id_hlt = 1'b1;
        want(c_V_DRAIN, "hlt");                         tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            want(c_V_DRAIN, "drain");                   tick();
        end
        want(c_V_HALT, "halted_5");                     tick();
        id_hlt = 1'b1; mem_redirect = 1'b1; set_lu_rs5();
        want(c_V_HALT, "halted_ignores"); want_cnt(0, 0); tick();
        idle();
        want(c_V_HALT, "halted_stays"); want_cnt(0, 0); tick();

        do_reset();
        id_hlt = 1'b1;
        want(c_V_DRAIN, "hlt_fz");                      tick();
        idle();
        want(c_V_DRAIN, "drain_fz_a");                  tick();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            want(c_V_FREEZE, "drain_freeze");           tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            want(c_V_DRAIN, "drain_fz_b");              tick();
        end
        want(c_V_HALT, "halted_7");                     tick();

        do_reset();
        id_hlt = 1'b1;
        want(c_V_DRAIN, "hlt_sq");                      tick();
        idle();
        want(c_V_DRAIN, "sq_drain1");                   tick();
        mem_redirect = 1'b1;
        want(c_V_REDIR, "squash");                      tick();
        idle();
        want(c_V_RUN, "squash_run"); want_cnt(0, 1);    tick();
        for (int i = 0; i < 6; i++) begin
            want(c_V_RUN, "squash_no_halt");            tick();
        end

        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) < 2);
            id_rs        = 4'($urandom_range(0, 3));
            id_rt        = 4'($urandom_range(0, 3));
            ex_Rd        = 4'($urandom_range(0, 3));
            id_use_rs    = 1'($urandom_range(0, 1));
            id_use_rt    = 1'($urandom_range(0, 1));
            id_hlt       = ($urandom_range(0, 99) < 4);
            ex_MemRead   = ($urandom_range(0, 99) < 40);
            mem_redirect = ($urandom_range(0, 99) < 12);
            mem_req      = ($urandom_range(0, 99) < 30);
            mem_ready    = 1'($urandom_range(0, 1));
            tick();
        end

        idle();
        rst = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
